// File: rtl/scoreboard_ctrl_multi.sv
// Multi-level game scoreboard: per-level BCD countdown, BCD score with late bonus, level advance.
// Optional macro SCORE_SAT_EN: score saturates at all nines instead of wrapping.
module scoreboard_ctrl_multi #(
  parameter int SCORE_DIGITS = 3,
  parameter int TIMER_INIT   = 60,
  parameter int LEVELS       = 2,
  parameter int THRESHOLD    = 40,
  parameter int PT_NORMAL    = 2,
  parameter int PT_BONUS     = 3,
  parameter int BONUS_AT     = 15,
  parameter int TICK_DIV     = 50000000
) (
  input  logic                      clk,
  input  logic                      ClrS,
  input  logic                      st,
  input  logic                      pt,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                timer_bcd,
  output logic [3:0]                level_bcd,
  output logic                      bonus,
  output logic                      done,
  output logic                      passed
);

  localparam int SCORE_MAX = 10 ** SCORE_DIGITS - 1;
  localparam int SW        = $clog2(SCORE_MAX + 1);
  localparam int PW        = $clog2(TICK_DIV);
  localparam logic [7:0] TIMER_BCD = 8'((TIMER_INIT / 10) * 16 + TIMER_INIT % 10);
  localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  // state  | meaning
  // S_IDLE | waiting for st, outputs hold last game
  // S_LOAD | clear score/level/timer for a new game
  // S_RUN  | timer counting down, points scored
  // S_EVAL | compare score with level threshold
  // S_NEXT | advance level, reload timer
  // S_DONE | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_EVAL, S_NEXT, S_DONE
  } state_t;

  logic [1:0]                rst_sync_q;
  logic                      rst_int;
  state_t                    state_q, state_d;
  logic [4*SCORE_DIGITS-1:0] score_q, score_d, score_sum, score_inc;
  logic [SW-1:0]             shadow_q, shadow_d, shadow_inc;
  logic [SW:0]               shadow_sum;
  logic                      shadow_ovf;
  logic [7:0]                timer_q, timer_d, timer_dec;
  logic [3:0]                level_q, level_d;
  logic                      passed_q, passed_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic                      pt_q, pt_hist_q;
  logic                      pt_edge, tick;
  logic [3:0]                pts;
  logic [4:0]                digit;
  logic                      carry;
  logic [6:0]                timer_sec;
  logic [31:0]               need;

  // Assertion is immediate; release is delayed two clocks to stay clear of the edge.
  always_ff @(posedge clk or posedge ClrS) begin
    if (ClrS) rst_sync_q <= 2'b11;
    else      rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      shadow_q  <= '0;
      timer_q   <= TIMER_BCD;
      level_q   <= 4'd1;
      passed_q  <= 1'b0;
      presc_q   <= '0;
      pt_q      <= 1'b0;
      pt_hist_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      shadow_q  <= shadow_d;
      timer_q   <= timer_d;
      level_q   <= level_d;
      passed_q  <= passed_d;
      presc_q   <= presc_d;
      pt_q      <= pt;
      pt_hist_q <= pt_q;
    end
  end

  assign pt_edge   = pt_q & ~pt_hist_q;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign timer_sec = 7'(timer_q[7:4]) * 7'd10 + 7'(timer_q[3:0]);
  assign bonus     = (state_q == S_RUN) && (32'(timer_sec) <= 32'(BONUS_AT)) &&
                     (timer_sec != 7'd0);
  assign timer_dec = (timer_q[3:0] == 4'd0) ? {timer_q[7:4] - 4'd1, 4'd9}
                                            : {timer_q[7:4], timer_q[3:0] - 4'd1};
  assign need      = 32'(THRESHOLD) * 32'(level_q);

  // Digit-serial BCD add of the strobe value, with a binary shadow kept in lockstep.
  always_comb begin
    pts       = bonus ? 4'(PT_BONUS) : 4'(PT_NORMAL);
    score_sum = '0;
    carry     = 1'b0;
    digit     = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      digit = {1'b0, score_q[4*i +: 4]} + {4'd0, carry};
      if (i == 0) digit = digit + {1'b0, pts};
      if (digit > 5'd9) begin
        digit = digit - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      score_sum[4*i +: 4] = digit[3:0];
    end
    shadow_sum = {1'b0, shadow_q} + (SW+1)'(pts);
    shadow_ovf = shadow_sum > (SW+1)'(SCORE_MAX);
`ifdef SCORE_SAT_EN
    score_inc  = shadow_ovf ? ALL_NINES : score_sum;
    shadow_inc = shadow_ovf ? SW'(SCORE_MAX) : shadow_sum[SW-1:0];
`else
    score_inc  = score_sum;
    shadow_inc = shadow_ovf ? SW'(shadow_sum - (SW+1)'(SCORE_MAX + 1)) : shadow_sum[SW-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    shadow_d = shadow_q;
    timer_d  = timer_q;
    level_d  = level_q;
    passed_d = passed_q;
    presc_d  = presc_q;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (st) state_d = S_LOAD;
      end
      S_LOAD: begin
        score_d  = '0;
        shadow_d = '0;
        level_d  = 4'd1;
        timer_d  = TIMER_BCD;
        passed_d = 1'b0;
        presc_d  = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (pt_edge) begin
          score_d  = score_inc;
          shadow_d = shadow_inc;
        end
        if (tick) begin
          presc_d = '0;
          timer_d = timer_dec;
          if (timer_dec == 8'h00) state_d = S_EVAL;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (32'(shadow_q) >= need) begin
          if (level_q < 4'(LEVELS)) begin
            state_d = S_NEXT;
          end else begin
            passed_d = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
          passed_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_NEXT: begin
        level_d = level_q + 4'd1;
        timer_d = TIMER_BCD;
        presc_d = '0;
        state_d = S_RUN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign score_bcd = score_q;
  assign timer_bcd = timer_q;
  assign level_bcd = level_q;
  assign passed    = passed_q;

endmodule
